memory_sequencer: RTL and testbench
===================================

// Module: memory_sequencer
//
// PURPOSE
//   Sequences the single-cycle datapath over one shared, single-port, variable-latency memory bus.
//   Fetches each instruction into a held inst register and performs the optional load/store.
//   Then issues a one-cycle commit strobe; control ANDs commit into pc_write_enable and
//   regfile_write_enable. Sits between the datapath and the external memory bus.
//
// PARAMETERS
//   TIMEOUT_CYCLES  255           consecutive not-ready cycles tolerated before bus_error; 0 = never time out
//   NOP_INST        32'h00000013  inst value after reset (addi x0,x0,0)
//
// PORTS
//   clock                  in   1   system clock, rising edge
//   reset                  in   1   asynchronous, active-high
//   pc                     in   32  current PC from datapath
//   data_mem_address       in   32  load/store address (ALU result)
//   data_mem_write_data    in   32  store data (rs2)
//   data_mem_format        in   3   funct3 access format
//   mem_read               in   1   decoded current inst is a load
//   mem_write              in   1   decoded current inst is a store
//   inst                   out  32  registered instruction driving the datapath
//   data_mem_data_fetched  out  32  registered load data to writeback mux
//   commit                 out  1   one-cycle strobe: retire current instruction
//   bus_req                out  1   bus transfer request
//   bus_write              out  1   1 = write, 0 = read
//   bus_address            out  32  bus address
//   bus_write_data         out  32  bus write data
//   bus_format             out  3   bus access format (funct3 encoding)
//   bus_ready              in   1   transfer completes when bus_req & bus_ready at rising edge
//   bus_read_data          in   32  read data, valid when bus_ready
//   bus_error              out  1   sticky timeout flag
//
// BEHAVIOUR
//   - States: FETCH, EXEC, DATA, COMMIT, HALT. Reset (async) -> FETCH.
//   - Reset values: inst = NOP_INST, data_mem_data_fetched = 0, commit = 0, bus_error = 0,
//     wait counter = 0. While reset is high, bus_req = 0 and bus_write = 0.
//   - bus_req = 1 only in FETCH and DATA. Address, data, format and write are stable
//     while bus_req & !bus_ready. bus_ready with bus_req = 0 is ignored.
//   - FETCH: bus_address = pc, bus_write = 0, bus_format = 3'b010.
//     On ready: inst <= bus_read_data, go to EXEC.
//   - EXEC: one cycle for decode and ALU to settle on the new inst.
//     If mem_read | mem_write, go to DATA; otherwise go to COMMIT.
//   - DATA: bus_address = data_mem_address, bus_write = mem_write,
//     bus_write_data = data_mem_write_data, bus_format = data_mem_format.
//     On ready: for a read, data_mem_data_fetched <= bus_read_data. Then go to COMMIT.
//   - mem_read & mem_write both high: treated as a store; data_mem_data_fetched is unchanged.
//   - COMMIT: commit = 1 for exactly one cycle, then go to FETCH. PC and regfile update at
//     that edge. inst is held until the next fetch completes.
//   - Outside FETCH and DATA: bus_address, bus_write_data and bus_format are don't-care;
//     bus_write = 0.
//   - Zero-wait latency: 3 cycles per ALU/branch/jump instruction; 4 cycles per load/store.
//   - data_mem_data_fetched holds its value between loads.
//   - Timeout (TIMEOUT_CYCLES > 0): the counter clears on entry to FETCH/DATA and increments
//     each cycle bus_req & !bus_ready. When it reaches TIMEOUT_CYCLES, go to HALT.
//     Counter width is $clog2(TIMEOUT_CYCLES+1).
//   - HALT: bus_error = 1, bus_req = 0, commit = 0. Only reset exits HALT.
//   - Reset mid-transfer: bus_req drops immediately; no commit is issued.
//     Fetch restarts from pc after reset release.
//
// TESTING
//   1. Reset release, bus_ready = 1, mem word at pc 0 = 0x00500093:
//      -> inst = 0x00500093 from cycle 1, commit high in cycle 2 only, next bus_req in cycle 3.
//   2. lw, DATA ready delayed 2 cycles, rdata 0xDEADBEEF:
//      -> bus_address = data_mem_address stable for 3 cycles,
//         data_mem_data_fetched = 0xDEADBEEF, commit in cycle 5.
//   3. sw with data_mem_write_data = 0x12345678, format 3'b010:
//      -> bus_write = 1, bus_write_data = 0x12345678, bus_format = 3'b010,
//         data_mem_data_fetched unchanged.
//   4. TIMEOUT_CYCLES = 4, bus_ready = 0 in FETCH:
//      -> HALT after 4 wait cycles; bus_error = 1, bus_req = 0, commit = 0 for 20 cycles;
//         reset clears bus_error.
//   5. Reset pulse during a DATA wait:
//      -> bus_req = 0 the same cycle, inst = 0x00000013, no commit; FETCH restarts after release.
//   6. mem_read = mem_write = 1 -> store performed, bus_write = 1, load register unchanged.

Source files
------------

// File: rtl/memory_sequencer.sv
// Sequences instruction fetch, optional load/store and a one-cycle commit strobe
// over a single shared variable-latency memory bus.
module memory_sequencer #(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter logic [31:0] NOP_INST       = 32'h00000013
) (
   input  logic        clock_i,
   input  logic        reset_i,
   input  logic [31:0] pc_i,
   input  logic [31:0] data_mem_address_i,
   input  logic [31:0] data_mem_write_data_i,
   input  logic [2:0]  data_mem_format_i,
   input  logic        mem_read_i,
   input  logic        mem_write_i,
   output logic [31:0] inst_o,
   output logic [31:0] data_mem_data_fetched_o,
   output logic        commit_o,
   output logic        bus_req_o,
   output logic        bus_write_o,
   output logic [31:0] bus_address_o,
   output logic [31:0] bus_write_data_o,
   output logic [2:0]  bus_format_o,
   input  logic        bus_ready_i,
   input  logic [31:0] bus_read_data_i,
   output logic        bus_error_o
);

   localparam int unsigned CntW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

   typedef enum logic [2:0] {StFetch, StExec, StData, StCommit, StHalt} state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [31:0]     inst_q, inst_d;
   logic [31:0]     rdata_q, rdata_d;
   logic            timeout;

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= StFetch;
         cnt_q   <= '0;
         inst_q  <= NOP_INST;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         inst_q  <= inst_d;
         rdata_q <= rdata_d;
      end
   end

   always_comb begin
      state_d          = state_q;
      cnt_d            = '0;
      inst_d           = inst_q;
      rdata_d          = rdata_q;
      bus_req_o        = 1'b0;
      bus_write_o      = 1'b0;
      bus_address_o    = pc_i;
      bus_write_data_o = data_mem_write_data_i;
      bus_format_o     = 3'b010;
      commit_o         = 1'b0;
      bus_error_o      = 1'b0;
      // The cycle that would bring the wait count up to TIMEOUT_CYCLES halts instead.
      timeout          = (TIMEOUT_CYCLES != 0) && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

      unique case (state_q)
         StFetch: begin
            bus_req_o = 1'b1;
            if (bus_ready_i) begin
               inst_d  = bus_read_data_i;
               state_d = StExec;
            end else if (timeout) begin
               state_d = StHalt;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StExec: begin
            state_d = (mem_read_i || mem_write_i) ? StData : StCommit;
         end
         StData: begin
            bus_req_o     = 1'b1;
            bus_write_o   = mem_write_i;
            bus_address_o = data_mem_address_i;
            bus_format_o  = data_mem_format_i;
            if (bus_ready_i) begin
               // A simultaneous read+write request is a store; the load register holds.
               if (mem_read_i && !mem_write_i) rdata_d = bus_read_data_i;
               state_d = StCommit;
            end else if (timeout) begin
               state_d = StHalt;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StCommit: begin
            commit_o = 1'b1;
            state_d  = StFetch;
         end
         StHalt: begin
            bus_error_o = 1'b1;
         end
         default: begin
            state_d = StFetch;
         end
      endcase

      if (reset_i) begin
         bus_req_o   = 1'b0;
         bus_write_o = 1'b0;
      end
   end

   assign inst_o                  = inst_q;
   assign data_mem_data_fetched_o = rdata_q;

endmodule

// File: tb/tb_memory_sequencer.sv
// Self-checking bench for memory_sequencer: directed scenarios plus randomized
// instruction streams checked against a per-instruction timeline model.
module tb_memory_sequencer;

   localparam int unsigned TO  = 4;
   localparam logic [31:0] NOP = 32'h00000013;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] pc, dm_addr, dm_wdata;
   logic [2:0]  dm_fmt;
   logic        mem_read, mem_write;
   logic [31:0] inst, fetched;
   logic        commit, bus_req, bus_write, bus_error;
   logic [31:0] bus_address, bus_wdata;
   logic [2:0]  bus_format;
   logic        bus_ready;
   logic [31:0] bus_rdata;

   int          n_pass  = 0;
   int          n_total = 0;
   logic [31:0] exp_fetched;
   logic [31:0] cur_pc;

   memory_sequencer #(.TIMEOUT_CYCLES(TO), .NOP_INST(NOP)) dut (
      .clock_i                 (clk),
      .reset_i                 (rst),
      .pc_i                    (pc),
      .data_mem_address_i      (dm_addr),
      .data_mem_write_data_i   (dm_wdata),
      .data_mem_format_i       (dm_fmt),
      .mem_read_i              (mem_read),
      .mem_write_i             (mem_write),
      .inst_o                  (inst),
      .data_mem_data_fetched_o (fetched),
      .commit_o                (commit),
      .bus_req_o               (bus_req),
      .bus_write_o             (bus_write),
      .bus_address_o           (bus_address),
      .bus_write_data_o        (bus_wdata),
      .bus_format_o            (bus_format),
      .bus_ready_i             (bus_ready),
      .bus_read_data_i         (bus_rdata),
      .bus_error_o             (bus_error)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // One instruction: fw/dw are not-ready cycles before the fetch/data transfer completes.
   // kind: 0 = ALU, 1 = load, 2 = store, 3 = read+write (behaves as store).
   task automatic run_instr(input int kind, input int fw, input int dw,
                            input logic [31:0] word, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [2:0] fmt,
                            input logic [31:0] rdata);
      logic mr, mw;
      mr = (kind == 1) || (kind == 3);
      mw = (kind >= 2);
      pc = cur_pc;
      mem_read = 1'b0;
      mem_write = 1'b0;
      for (int c = 0; c <= fw; c++) begin
         bus_ready = (c == fw);
         bus_rdata = (c == fw) ? word : $urandom;
         #1;
         n_total++;
         if ({bus_req, bus_write, commit, bus_error} !== 4'b1000)
            $display("FAIL fetch_ctrl got %b exp 1000", {bus_req, bus_write, commit, bus_error});
         else n_pass++;
         n_total++;
         if ({bus_address, bus_format} !== {cur_pc, 3'b010})
            $display("FAIL fetch_addr got %h/%b exp %h/010", bus_address, bus_format, cur_pc);
         else n_pass++;
         tick();
      end
      mem_read = mr;
      mem_write = mw;
      dm_addr = addr;
      dm_wdata = wdata;
      dm_fmt = fmt;
      bus_ready = 1'($urandom_range(1, 0));
      bus_rdata = $urandom;
      #1;
      n_total++;
      if ({bus_req, bus_write, commit, bus_error, inst} !== {4'b0000, word})
         $display("FAIL exec got %b/%h exp 0000/%h", {bus_req, bus_write, commit, bus_error},
                  inst, word);
      else n_pass++;
      tick();
      if (mr || mw) begin
         for (int c = 0; c <= dw; c++) begin
            bus_ready = (c == dw);
            bus_rdata = (c == dw) ? rdata : $urandom;
            #1;
            n_total++;
            if ({bus_req, bus_write, commit, bus_error} !== {1'b1, mw, 2'b00})
               $display("FAIL data_ctrl got %b exp %b", {bus_req, bus_write, commit, bus_error},
                        {1'b1, mw, 2'b00});
            else n_pass++;
            n_total++;
            if ({bus_address, bus_format} !== {addr, fmt})
               $display("FAIL data_addr got %h/%b exp %h/%b", bus_address, bus_format, addr, fmt);
            else n_pass++;
            if (mw) begin
               n_total++;
               if (bus_wdata !== wdata)
                  $display("FAIL store_data got %h exp %h", bus_wdata, wdata);
               else n_pass++;
            end
            tick();
         end
      end
      if (kind == 1) exp_fetched = rdata;
      bus_ready = 1'($urandom_range(1, 0));
      #1;
      n_total++;
      if ({bus_req, bus_write, commit, bus_error, inst} !== {4'b0010, word})
         $display("FAIL commit got %b/%h exp 0010/%h", {bus_req, bus_write, commit, bus_error},
                  inst, word);
      else n_pass++;
      n_total++;
      if (fetched !== exp_fetched)
         $display("FAIL load_reg got %h exp %h", fetched, exp_fetched);
      else n_pass++;
      tick();
      cur_pc = cur_pc + 32'd4;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      pc = '0;
      dm_addr = '0;
      dm_wdata = '0;
      dm_fmt = '0;
      mem_read = 1'b0;
      mem_write = 1'b1;
      bus_ready = 1'b0;
      bus_rdata = 32'hA5A5A5A5;
      repeat (2) tick();
      bus_ready = 1'b1;
      #1;
      n_total++;
      if ({bus_req, bus_write, commit, bus_error} !== 4'b0000)
         $display("FAIL reset_ctrl got %b exp 0000", {bus_req, bus_write, commit, bus_error});
      else n_pass++;
      tick();
      n_total++;
      if ({inst, fetched} !== {NOP, 32'h0})
         $display("FAIL reset_regs got %h/%h exp %h/0", inst, fetched, NOP);
      else n_pass++;
      mem_write = 1'b0;
      rst = 1'b0;
      exp_fetched = '0;
      cur_pc = '0;
   endtask

   task automatic test_first_fetch;
      pc = 32'h0;
      bus_ready = 1'b1;
      bus_rdata = 32'h00500093;
      #1;
      n_total++;
      if ({bus_req, bus_write, bus_address, bus_format} !== {2'b10, 32'h0, 3'b010})
         $display("FAIL ff_c0 got %b%b %h %b", bus_req, bus_write, bus_address, bus_format);
      else n_pass++;
      tick();
      bus_rdata = $urandom;
      n_total++;
      if ({inst, bus_req, commit} !== {32'h00500093, 2'b00})
         $display("FAIL ff_c1 got %h %b%b exp 00500093 00", inst, bus_req, commit);
      else n_pass++;
      tick();
      n_total++;
      if ({bus_req, commit} !== 2'b01) $display("FAIL ff_c2 got %b exp 01", {bus_req, commit});
      else n_pass++;
      tick();
      n_total++;
      if ({bus_req, commit} !== 2'b10) $display("FAIL ff_c3 got %b exp 10", {bus_req, commit});
      else n_pass++;
      cur_pc = 32'h4;
   endtask

   task automatic test_load_wait;
      run_instr(1, 0, 2, 32'h0000A103, 32'h00001000, 32'h0, 3'b010, 32'hDEADBEEF);
   endtask

   task automatic test_store;
      run_instr(2, 1, 0, 32'h00B12023, 32'h00002000, 32'h12345678, 3'b010, 32'h0BADF00D);
   endtask

   task automatic test_both_rw;
      run_instr(3, 0, 1, 32'h00C1A023, 32'h00003004, 32'hCAFEF00D, 3'b001, 32'h55AA55AA);
   endtask

   task automatic test_random;
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(3, 0) == 0) cur_pc = $urandom & 32'hFFFF_FFFC;
         run_instr(int'($urandom_range(3, 0)), int'($urandom_range(TO - 1, 0)),
                   int'($urandom_range(TO - 1, 0)), $urandom, $urandom, $urandom,
                   3'($urandom_range(7, 0)), $urandom);
      end
   endtask

   task automatic test_reset_mid;
      pc = cur_pc;
      bus_ready = 1'b1;
      bus_rdata = 32'h0000A183;
      tick();
      mem_read = 1'b1;
      mem_write = 1'b0;
      dm_addr = 32'h00004000;
      bus_ready = 1'b0;
      tick();
      #1;
      n_total++;
      if (bus_req !== 1'b1) $display("FAIL rm_data got %b exp 1", bus_req);
      else n_pass++;
      tick();
      rst = 1'b1;
      #1;
      n_total++;
      if ({bus_req, commit, inst} !== {2'b00, NOP})
         $display("FAIL rm_assert got %b%b %h exp 00 %h", bus_req, commit, inst, NOP);
      else n_pass++;
      bus_ready = 1'b1;
      tick();
      n_total++;
      if ({bus_req, commit, fetched} !== {2'b00, 32'h0})
         $display("FAIL rm_hold got %b%b %h exp 00 0", bus_req, commit, fetched);
      else n_pass++;
      rst = 1'b0;
      bus_ready = 1'b0;
      mem_read = 1'b0;
      exp_fetched = '0;
      #1;
      n_total++;
      if ({bus_req, bus_write, bus_address} !== {2'b10, cur_pc})
         $display("FAIL rm_restart got %b%b %h exp 10 %h", bus_req, bus_write, bus_address, cur_pc);
      else n_pass++;
   endtask

   task automatic test_timeout;
      bus_ready = 1'b0;
      for (int c = 0; c < int'(TO); c++) begin
         #1;
         n_total++;
         if ({bus_req, bus_error} !== 2'b10)
            $display("FAIL to_wait%0d got %b exp 10", c, {bus_req, bus_error});
         else n_pass++;
         tick();
      end
      for (int c = 0; c < 20; c++) begin
         bus_ready = 1'($urandom_range(1, 0));
         #1;
         n_total++;
         if ({bus_req, bus_write, commit, bus_error} !== 4'b0001)
            $display("FAIL halt%0d got %b exp 0001", c, {bus_req, bus_write, commit, bus_error});
         else n_pass++;
         tick();
      end
      rst = 1'b1;
      #1;
      n_total++;
      if ({bus_req, bus_error} !== 2'b00)
         $display("FAIL to_reset got %b exp 00", {bus_req, bus_error});
      else n_pass++;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_first_fetch();
      test_load_wait();
      test_store();
      test_both_rw();
      test_random();
      test_reset_mid();
      test_timeout();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
